station_tuner: RTL and testbench

Channel tuner and soft-mute stage placed directly ahead of `radio_core` and behind its audio output. It debounces up and down push buttons and steps a channel index through the FM band, wrapping at both ends. It drives the DDS phase constant `K` into `radio_core`. During each retune it fades the demodulated audio down to silence, swaps `K`, waits for the loop to settle, then fades back up, so station changes are click-free at the `wm8731_controller` input.

---
 rtl/tuner_pkg.sv | 25 ++
 rtl/key_debounce.sv | 46 ++++
 rtl/station_tuner.sv | 170 +++++++++++++++++
 tb/tb_station_tuner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// Shared types and constants for the station tuner: FSM states, gain format,
// scan-hold length and the debug view of the control state.
package tuner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        RETUNE,
        SETTLE,
        FADE_IN
    } tuner_state_t;

    localparam int                GAIN_W    = 9;
    localparam logic [GAIN_W-1:0] GAIN_ONE  = 9'd256;
    localparam int                SCAN_HOLD = 16000;

    typedef struct packed {
        tuner_state_t state;
        logic         pend_valid;
        logic         pend_up;
        logic         lvl_up;
        logic         lvl_dn;
    } tuner_dbg_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, en32k-rate debounce counter and
// a one-cycle pulse (on the en32k cycle) when the debounced level rises.
module key_debounce #(
    parameter int DEBOUNCE = 640
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic key_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          flip;

    // The counter tracks consecutive samples that disagree with the held level.
    assign flip = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_i};
            if (en_i) begin
                if (sync_q[1] == level_q) begin
                    cnt_q <= '0;
                end else if (flip) begin
                    cnt_q   <= '0;
                    level_q <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = en_i & flip & sync_q[1];

endmodule

// File: rtl/station_tuner.sv
// Channel tuner with click-free soft-mute retune sequencing.
// Define TUNER_SCAN_EN to enable auto-repeat while a key is held.
module station_tuner
    import tuner_pkg::*;
#(
    parameter int     width_dds    = 32,
    parameter longint K_BASE       = 1565873835,
    parameter int     K_STEP       = 1789570,
    parameter int     N_CHAN       = 206,
    parameter int     INIT_CHAN    = 0,
    parameter int     DEBOUNCE     = 640,
    parameter int     SETTLE_TICKS = 320
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en32k,
    input  logic                 key_up,
    input  logic                 key_down,
    input  logic signed [15:0]   demod_in,
    output logic signed [15:0]   audio_out,
    output logic [width_dds-1:0] K,
    output logic [7:0]           chan,
    output logic                 busy,
    output tuner_dbg_t           dbg_o
);
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam logic [width_dds-1:0] K_INIT  = width_dds'(K_BASE + longint'(INIT_CHAN) * longint'(K_STEP));
    localparam logic [width_dds-1:0] K_FIRST = width_dds'(K_BASE);
    localparam logic [width_dds-1:0] K_LAST  = width_dds'(K_BASE + longint'(N_CHAN - 1) * longint'(K_STEP));
    localparam logic [width_dds-1:0] K_INC   = width_dds'(K_STEP);

    tuner_state_t         state_q;
    logic [GAIN_W-1:0]    g_q;
    logic [SW-1:0]        settle_q;
    logic [7:0]           chan_q;
    logic [width_dds-1:0] k_q;
    logic                 busy_q, pend_valid_q, pend_up_q, dir_up_q;
    logic signed [15:0]   audio_q, audio_d;
    logic signed [23:0]   prod;
    logic                 up_level, up_rise, dn_level, dn_rise;
    logic                 scan_up, scan_dn, req_up, req_dn;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_up (
        .clk(clk), .reset(reset), .en_i(en32k), .key_i(key_up),
        .level_o(up_level), .rise_o(up_rise)
    );
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_dn (
        .clk(clk), .reset(reset), .en_i(en32k), .key_i(key_down),
        .level_o(dn_level), .rise_o(dn_rise)
    );

`ifdef TUNER_SCAN_EN
    localparam int HW = $clog2(SCAN_HOLD + 1);
    logic [HW-1:0] hold_up_q, hold_dn_q;

    // Hold counters saturate so a long press keeps re-arming on every IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_up_q <= '0;
            hold_dn_q <= '0;
        end else if (en32k) begin
            if (!up_level)                      hold_up_q <= '0;
            else if (hold_up_q != HW'(SCAN_HOLD)) hold_up_q <= hold_up_q + 1'b1;
            if (!dn_level)                      hold_dn_q <= '0;
            else if (hold_dn_q != HW'(SCAN_HOLD)) hold_dn_q <= hold_dn_q + 1'b1;
        end
    end

    assign scan_up = en32k && (hold_up_q == HW'(SCAN_HOLD)) && (state_q == IDLE) && !pend_valid_q;
    assign scan_dn = en32k && (hold_dn_q == HW'(SCAN_HOLD)) && (state_q == IDLE) && !pend_valid_q;
`else
    assign scan_up = 1'b0;
    assign scan_dn = 1'b0;
`endif

    // Coincident up and down requests cancel each other.
    assign req_up = (up_rise | scan_up) & ~(dn_rise | scan_dn);
    assign req_dn = (dn_rise | scan_dn) & ~(up_rise | scan_up);

    // |demod * g| <= 2^23, so a 24-bit signed product cannot overflow.
    assign prod    = 24'(demod_in) * 24'($signed({1'b0, g_q}));
    assign audio_d = 16'(prod >>> 8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SETTLE;
            g_q          <= '0;
            settle_q     <= '0;
            chan_q       <= 8'(INIT_CHAN);
            k_q          <= K_INIT;
            busy_q       <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_up_q    <= 1'b0;
            dir_up_q     <= 1'b0;
            audio_q      <= '0;
        end else if (en32k) begin
            audio_q <= audio_d;
            if (req_up || req_dn) begin
                pend_valid_q <= 1'b1;
                pend_up_q    <= req_up;
            end else if (state_q == IDLE && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    g_q <= GAIN_ONE;
                    if (pend_valid_q) begin
                        state_q  <= FADE_OUT;
                        busy_q   <= 1'b1;
                        dir_up_q <= pend_up_q;
                    end
                end
                FADE_OUT: begin
                    g_q <= g_q - 1'b1;
                    if (g_q == GAIN_W'(1)) state_q <= RETUNE;
                end
                RETUNE: begin
                    if (dir_up_q) begin
                        if (chan_q == 8'(N_CHAN - 1)) begin
                            chan_q <= '0;
                            k_q    <= K_FIRST;
                        end else begin
                            chan_q <= chan_q + 1'b1;
                            k_q    <= k_q + K_INC;
                        end
                    end else begin
                        if (chan_q == 8'd0) begin
                            chan_q <= 8'(N_CHAN - 1);
                            k_q    <= K_LAST;
                        end else begin
                            chan_q <= chan_q - 1'b1;
                            k_q    <= k_q - K_INC;
                        end
                    end
                    settle_q <= '0;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SW'(SETTLE_TICKS - 1)) begin
                        settle_q <= '0;
                        state_q  <= FADE_IN;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                FADE_IN: begin
                    g_q <= g_q + 1'b1;
                    if (g_q == GAIN_ONE - 1'b1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                    g_q      <= '0;
                    busy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign audio_out = audio_q;
    assign K         = k_q;
    assign chan      = chan_q;
    assign busy      = busy_q;
    assign dbg_o     = '{state: state_q, pend_valid: pend_valid_q, pend_up: pend_up_q,
                         lvl_up: up_level, lvl_dn: dn_level};

endmodule

// File: tb/tb_station_tuner.sv
// Directed bench for station_tuner: soft start, gain scaling, retunes with wrap,
// debounce, pending and simultaneous requests, and asynchronous reset mid-fade.
module tb_station_tuner;
    import tuner_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               en32k = 1'b0;
    logic               key_up = 1'b0;
    logic               key_down = 1'b0;
    logic signed [15:0] demod_in = '0;
    logic signed [15:0] audio_out;
    logic [31:0]        K;
    logic [7:0]         chan;
    logic               busy;
    tuner_dbg_t         dbg;

    int          passed = 0;
    int          total = 0;
    logic [31:0] k_prev = '0;

    localparam logic [31:0] K0   = 32'd1565873835;
    localparam logic [31:0] K1   = 32'd1567663405;
    localparam logic [31:0] K205 = 32'd1932735685;

    station_tuner dut (
        .clk(clk), .reset(reset), .en32k(en32k), .key_up(key_up), .key_down(key_down),
        .demod_in(demod_in), .audio_out(audio_out), .K(K), .chan(chan), .busy(busy),
        .dbg_o(dbg)
    );

    always #5 clk = ~clk;
    always @(negedge clk) en32k = ~en32k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One en32k tick; any K change must coincide with silent audio.
    task automatic step();
        do @(posedge clk); while (en32k !== 1'b1);
        #1;
        if (K !== k_prev) begin
            chk("k_change_silent", {16'h0, audio_out}, 32'h0);
            k_prev = K;
        end
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        key_up = up;
        key_down = dn;
        repeat (hold) step();
        key_up = 1'b0;
        key_down = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin
            step();
            n++;
        end
        chk("idle_reached", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        demod_in = 16'sh4000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_audio", {16'h0, audio_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_chan", {24'h0, chan}, 32'd0);
        chk("rst_k", K, K0);
        chk("rst_state", {29'h0, dbg.state}, {29'h0, SETTLE});
        @(posedge clk);
        #1 reset = 1'b0;
        k_prev = K;

        // Soft start: 320 silent ticks, then a 256-tick ramp.
        step();
        chk("settle_silent", {16'h0, audio_out}, 32'h0);
        repeat (447) step();
        step();
        chk("gain_128_pos", {16'h0, audio_out}, 32'h2000);
        demod_in = 16'shC000;
        step();
        chk("gain_129_neg", {16'h0, audio_out}, 32'hDFC0);
        repeat (125) step();
        chk("busy_575", {31'h0, busy}, 32'h1);
        step();
        chk("idle_576", {31'h0, busy}, 32'h0);
        demod_in = 16'sh7FFF;
        step();
        chk("unity_7fff", {16'h0, audio_out}, 32'h7FFF);
        demod_in = 16'sh8000;
        step();
        chk("unity_8000", {16'h0, audio_out}, 32'h8000);
        demod_in = 16'sh7FFF;

        press(1'b1, 1'b0, 700);
        wait_idle(1500);
        chk("up_chan", {24'h0, chan}, 32'd1);
        chk("up_k", K, K1);

        press(1'b0, 1'b1, 700);
        wait_idle(1500);
        chk("down_chan", {24'h0, chan}, 32'd0);
        chk("down_k", K, K0);

        press(1'b0, 1'b1, 700);
        wait_idle(1500);
        chk("wrap_down_chan", {24'h0, chan}, 32'd205);
        chk("wrap_down_k", K, K205);

        press(1'b1, 1'b0, 700);
        wait_idle(1500);
        chk("wrap_up_chan", {24'h0, chan}, 32'd0);
        chk("wrap_up_k", K, K0);

        press(1'b1, 1'b0, 600);
        repeat (700) step();
        chk("glitch_busy", {31'h0, busy}, 32'h0);
        chk("glitch_level", {31'h0, dbg.lvl_up}, 32'h0);
        chk("glitch_chan", {24'h0, chan}, 32'd0);

        key_up = 1'b1;
        key_down = 1'b1;
        repeat (700) step();
        chk("simul_level", {31'h0, dbg.lvl_up}, 32'h1);
        chk("simul_busy", {31'h0, busy}, 32'h0);
        chk("simul_pend", {31'h0, dbg.pend_valid}, 32'h0);
        key_up = 1'b0;
        key_down = 1'b0;
        repeat (700) step();
        chk("simul_chan", {24'h0, chan}, 32'd0);

        // Down request lands while the up retune is in SETTLE.
        key_up = 1'b1;
        repeat (300) step();
        key_down = 1'b1;
        repeat (400) step();
        key_up = 1'b0;
        repeat (400) step();
        chk("pend_state", {29'h0, dbg.state}, {29'h0, SETTLE});
        chk("pend_valid", {31'h0, dbg.pend_valid}, 32'h1);
        chk("pend_dir", {31'h0, dbg.pend_up}, 32'h0);
        chk("pend_mid_chan", {24'h0, chan}, 32'd1);
        key_down = 1'b0;
        repeat (1000) step();
        wait_idle(1500);
        chk("pend_final_chan", {24'h0, chan}, 32'd0);
        chk("pend_final_k", K, K0);

        press(1'b1, 1'b0, 700);
        wait_idle(1500);
        chk("pre_rst_chan", {24'h0, chan}, 32'd1);

        // Unit-level input makes audio_out read back the gain directly.
        demod_in = 16'sh0100;
        key_up = 1'b1;
        begin
            int n = 0;
            while (busy !== 1'b1 && n < 1000) begin
                step();
                n++;
            end
        end
        chk("fo_entered", {31'h0, busy}, 32'h1);
        key_up = 1'b0;
        repeat (156) step();
        chk("fo_state", {29'h0, dbg.state}, {29'h0, FADE_OUT});
        chk("fo_gain_101", {16'h0, audio_out}, 32'd101);
        reset = 1'b1;
        #1;
        chk("midrst_audio", {16'h0, audio_out}, 32'h0);
        chk("midrst_chan", {24'h0, chan}, 32'd0);
        chk("midrst_busy", {31'h0, busy}, 32'h1);
        chk("midrst_k", K, K0);
        chk("midrst_state", {29'h0, dbg.state}, {29'h0, SETTLE});
        @(posedge clk);
        #1 reset = 1'b0;
        k_prev = K;
        wait_idle(700);
        chk("post_rst_chan", {24'h0, chan}, 32'd0);

`ifdef TUNER_SCAN_EN
        demod_in = 16'sh7FFF;
        key_up = 1'b1;
        repeat (19000) step();
        chk("scan_advance", {31'h0, (chan >= 8'd3)}, 32'h1);
        key_up = 1'b0;
        wait_idle(1500);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
